imm_extract_stage: RTL and testbench

// Decode-side producer for the immediate mux: captures a 16-bit instruction word plus its im_op selector, registers all

---
 rtl/imm_extract_stage.sv | 134 +++++++++++++
 tb/tb_imm_extract_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extract_stage.sv
// Registers the five extended immediates of a 16-bit instruction behind a 2-entry skid buffer.
// 1-cycle latency, 1/cycle sustained; in_ready is registered (~skid full), so out_ready never reaches in_ready combinationally.
module imm_extract_stage #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] inst,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] im_s_e3_0,
  output logic [DATA_W-1:0] im_s_e4_0,
  output logic [DATA_W-1:0] im_s_e7_0,
  output logic [DATA_W-1:0] im_s_e10_0,
  output logic [DATA_W-1:0] im_z_e7_0,
  output logic [OP_W-1:0]   im_op
);

  localparam logic [OP_W-1:0] IM_OP_NOP = '0;

  typedef struct packed {
    logic [DATA_W-1:0] s3;
    logic [DATA_W-1:0] s4;
    logic [DATA_W-1:0] s7;
    logic [DATA_W-1:0] s10;
    logic [DATA_W-1:0] z7;
  } imm_t;

  function automatic imm_t f_ext(input logic [10:0] w);
    imm_t r;
    r.s3  = {{(DATA_W-4){w[3]}},   w[3:0]};
    r.s4  = {{(DATA_W-5){w[4]}},   w[4:0]};
    r.s7  = {{(DATA_W-8){w[7]}},   w[7:0]};
    r.s10 = {{(DATA_W-11){w[10]}}, w[10:0]};
    r.z7  = {{(DATA_W-8){1'b0}},   w[7:0]};
    return r;
  endfunction

  // Only the low 11 bits feed any extension; the skid keeps just those.
  logic w_unused;
  assign w_unused = ^inst[DATA_W-1:11];

  logic            r_main_v, r_skid_v;
  imm_t            r_imm;
  logic [OP_W-1:0] r_op;
  logic [10:0]     r_skid_inst;
  logic [OP_W-1:0] r_skid_op;

  logic w_acc, w_cons;
  logic w_main_v_nxt, w_skid_v_nxt;
  logic w_ld_in, w_ld_skid, w_cap_skid, w_op_nop;

  assign in_ready = ~r_skid_v;
  assign w_acc    = in_valid & ~r_skid_v;
  assign w_cons   = r_main_v & out_ready;

  always_comb begin
    w_main_v_nxt = r_main_v;
    w_skid_v_nxt = r_skid_v;
    w_ld_in      = 1'b0;
    w_ld_skid    = 1'b0;
    w_cap_skid   = 1'b0;
    w_op_nop     = 1'b0;
    if (flush) begin
      w_main_v_nxt = 1'b0;
      w_skid_v_nxt = 1'b0;
      w_op_nop     = 1'b0 | 1'b1;
    end else if (r_skid_v) begin
      // A lone skid entry (main empty) is promoted as if it had just been consumed past.
      if (w_cons || !r_main_v) begin
        w_ld_skid    = 1'b1;
        w_main_v_nxt = 1'b1;
        w_skid_v_nxt = 1'b0;
      end
    end else if (r_main_v) begin
      case ({w_acc, w_cons})
        2'b11: w_ld_in = 1'b1;
        2'b10: begin
          w_cap_skid   = 1'b1;
          w_skid_v_nxt = 1'b1;
        end
        2'b01: begin
          w_main_v_nxt = 1'b0;
          w_op_nop     = 1'b1;
        end
        default: ;
      endcase
    end else if (w_acc) begin
      w_ld_in      = 1'b1;
      w_main_v_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_v    <= 1'b0;
      r_skid_v    <= 1'b0;
      r_imm       <= '0;
      r_op        <= IM_OP_NOP;
      r_skid_inst <= '0;
      r_skid_op   <= IM_OP_NOP;
    end else begin
      r_main_v <= w_main_v_nxt;
      r_skid_v <= w_skid_v_nxt;
      if (w_ld_in) begin
        r_imm <= f_ext(inst[10:0]);
        r_op  <= in_op;
      end else if (w_ld_skid) begin
        r_imm <= f_ext(r_skid_inst);
        r_op  <= r_skid_op;
      end else if (w_op_nop) begin
        r_op <= IM_OP_NOP;
      end
      if (w_cap_skid) begin
        r_skid_inst <= inst[10:0];
        r_skid_op   <= in_op;
      end
    end
  end

  assign out_valid  = r_main_v;
  assign im_s_e3_0  = r_imm.s3;
  assign im_s_e4_0  = r_imm.s4;
  assign im_s_e7_0  = r_imm.s7;
  assign im_s_e10_0 = r_imm.s10;
  assign im_z_e7_0  = r_imm.z7;
  assign im_op      = r_op;

endmodule

// File: tb/tb_imm_extract_stage.sv
// Bench for imm_extract_stage: queue-based reference model checked every cycle, plus directed literal checks.
module tb_imm_extract_stage;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_S10 = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] inst = '0;
  logic [2:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] s3, s4, s7, s10, z7;
  logic [2:0]  op;

  imm_extract_stage #(.DATA_W(16), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .im_s_e3_0(s3), .im_s_e4_0(s4), .im_s_e7_0(s7), .im_s_e10_0(s10), .im_z_e7_0(z7),
    .im_op(op)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Extension by arithmetic: take the low k bits as a two's-complement number.
  function automatic logic [15:0] sext(input logic [15:0] w, input int k);
    int v;
    v = int'(w) % (1 << k);
    if (v >= (1 << (k - 1))) v -= (1 << k);
    return 16'(v);
  endfunction

  function automatic logic [15:0] zext8(input logic [15:0] w);
    return 16'(int'(w) % 256);
  endfunction

  typedef struct {
    logic [15:0] inst;
    logic [2:0]  op;
  } ent_t;

  ent_t        q[$];
  logic [15:0] last_inst = '0;

  // Reference: a FIFO of capacity 2; head visible the cycle after it is accepted.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      last_inst = '0;
    end else begin
      bit acc, cons;
      ent_t e;
      acc  = in_valid && (q.size() < 2);
      cons = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (cons) void'(q.pop_front());
        if (acc) begin
          e.inst = inst;
          e.op   = in_op;
          q.push_back(e);
        end
      end
      if (q.size() > 0) last_inst = q[0].inst;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] hi;
      logic [2:0]  hop;
      hi  = (q.size() > 0) ? q[0].inst : last_inst;
      hop = (q.size() > 0) ? q[0].op : OP_NOP;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("im_op", 32'(op), 32'(hop));
      chk("s_e3_0", 32'(s3), 32'(sext(hi, 4)));
      chk("s_e4_0", 32'(s4), 32'(sext(hi, 5)));
      chk("s_e7_0", 32'(s7), 32'(sext(hi, 8)));
      chk("s_e10_0", 32'(s10), 32'(sext(hi, 11)));
      chk("z_e7_0", 32'(z7), 32'(zext8(hi)));
      chk("no_skid_without_main", 32'(in_ready | out_valid), 32'd1);
      a_no_01: assert (in_ready || out_valid);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic v, input logic [15:0] w, input logic [2:0] o);
    in_valid = v;
    inst     = w;
    in_op    = o;
  endtask

  initial begin
    // Model pinned against hand-computed values.
    chk("model_s10_84FA", 32'(sext(16'h84FA, 11)), 32'h0000FCFA);
    chk("model_s4_0135", 32'(sext(16'h0135, 5)), 32'h0000FFF5);
    chk("model_s3_0135", 32'(sext(16'h0135, 4)), 32'h00000005);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_im_op", 32'(op), 32'(OP_NOP));
    chk("rst_s10", 32'(s10), 32'd0);
    rst    = 1'b1;
    chk_en = 1;

    // Directed: single words with known extensions.
    out_ready = 1'b1;
    offer(1'b1, 16'h84FA, OP_S10);
    cyc();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_s3", 32'(s3), 32'hFFFA);
    chk("t1_s4", 32'(s4), 32'hFFFA);
    chk("t1_s7", 32'(s7), 32'hFFFA);
    chk("t1_s10", 32'(s10), 32'hFCFA);
    chk("t1_z7", 32'(z7), 32'h00FA);
    chk("t1_op", 32'(op), 32'(OP_S10));
    offer(1'b1, 16'h0135, 3'd1);
    cyc();
    chk("t2_s3", 32'(s3), 32'h0005);
    chk("t2_s4", 32'(s4), 32'hFFF5);
    chk("t2_s7", 32'(s7), 32'h0035);
    chk("t2_s10", 32'(s10), 32'h0135);
    chk("t2_z7", 32'(z7), 32'h0035);
    offer(1'b0, 16'h0000, 3'd0);
    cyc();
    chk("t2_drain_valid", 32'(out_valid), 32'd0);
    chk("t2_drain_op", 32'(op), 32'(OP_NOP));

    // Directed: stall with A at head, B in skid, C held upstream.
    offer(1'b1, 16'h1111, 3'd2);
    cyc();
    out_ready = 1'b0;
    offer(1'b1, 16'h2222, 3'd3);
    cyc();
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    chk("t3_head_A", 32'(z7), 32'h0011);
    offer(1'b1, 16'h0333, 3'd5);
    cyc();
    chk("t3_hold_A", 32'(z7), 32'h0011);
    chk("t3_hold_op", 32'(op), 32'd2);
    out_ready = 1'b1;
    cyc();
    chk("t3_head_B", 32'(z7), 32'h0022);
    chk("t3_ready_again", 32'(in_ready), 32'd1);
    cyc();
    chk("t3_head_C", 32'(z7), 32'h0033);
    chk("t3_op_C", 32'(op), 32'd5);
    offer(1'b0, 16'h0000, 3'd0);
    cyc();
    chk("t3_empty", 32'(out_valid), 32'd0);

    // Directed: flush with both entries held and a word on offer.
    out_ready = 1'b0;
    offer(1'b1, 16'h0444, 3'd1);
    cyc();
    offer(1'b1, 16'h0555, 3'd2);
    cyc();
    flush = 1'b1;
    offer(1'b1, 16'h0666, 3'd3);
    cyc();
    flush = 1'b0;
    offer(1'b0, 16'h0000, 3'd0);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_ready", 32'(in_ready), 32'd1);
    chk("t4_op", 32'(op), 32'(OP_NOP));
    out_ready = 1'b1;
    repeat (2) cyc();
    chk("t4_nothing_leaks", 32'(out_valid), 32'd0);

    // Directed: reset asserted off the clock edge with the buffer full.
    out_ready = 1'b0;
    offer(1'b1, 16'h0777, 3'd6);
    cyc();
    offer(1'b1, 16'h0888, 3'd7);
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_op", 32'(op), 32'(OP_NOP));
    chk("t5_s3", 32'(s3), 32'd0);
    chk("t5_s10", 32'(s10), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    offer(1'b1, 16'h84FA, OP_S10);
    cyc();
    chk("t5_first_valid", 32'(out_valid), 32'd1);
    chk("t5_first_s10", 32'(s10), 32'hFCFA);
    offer(1'b0, 16'h0000, 3'd0);
    cyc();

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      inst      = 16'($urandom);
      in_op     = 3'($urandom_range(0, 7));
      cyc();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
